// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_seq_ctrl : multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV core.
// Rev 1.0
// ---------------------------------------------------------------------------
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        alu_load,
  input  logic        alu_store,
  input  logic        alu_wr_en,
  input  logic        alu_jump,
  input  logic        alu_beq,
  input  logic        alu_bneq,
  input  logic        alu_bge,
  input  logic        alu_ble,
  input  logic        jump_abs,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_mem_addr,
  input  logic [31:0] alu_immi_address,
  input  logic [31:0] alu_immi_address_jump,
  input  logic [31:0] st_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic [31:0] instret,
  input  logic        halt_req,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        store_q;

  logic [31:0] pc_plus4_d;
  logic        branch_d;

  assign pc_plus4_d = pc_q + 32'd4;
  assign branch_d   = alu_beq | alu_bneq | alu_bge | alu_ble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC;
      ir_q         <= '0;
      instret_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      store_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= halt_req ? S_HALT : S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Memory ops leave npc for MEM to set; everything else resolves here.
          if (alu_load) begin
            dmem_addr_q <= alu_mem_addr;
            store_q     <= 1'b0;
            we_q        <= 1'b0;
            state_q     <= S_MEM;
          end else if (alu_store) begin
            dmem_addr_q  <= alu_mem_addr;
            dmem_wdata_q <= st_data;
            store_q      <= 1'b1;
            we_q         <= 1'b0;
            state_q      <= S_MEM;
          end else if (alu_jump) begin
            wdata_q <= pc_plus4_d;
            we_q    <= 1'b1;
            npc_q   <= jump_abs ? (alu_immi_address_jump & ~32'h1)
                                : (pc_q + alu_immi_address_jump);
            state_q <= S_WB;
          end else if (branch_d) begin
            we_q    <= 1'b0;
            npc_q   <= pc_q + alu_immi_address;
            state_q <= S_WB;
          end else begin
            wdata_q <= alu_result;
            we_q    <= alu_wr_en;
            npc_q   <= pc_plus4_d;
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (!store_q) begin
              wdata_q <= dmem_rdata;
              we_q    <= 1'b1;
            end else begin
              we_q <= 1'b0;
            end
            npc_q   <= pc_plus4_d;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          pc_q      <= npc_q;
          instret_q <= instret_q + 32'd1;
          state_q   <= halt_req ? S_HALT : S_FETCH;
        end
        S_HALT: if (!halt_req) state_q <= S_FETCH;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && store_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign rf_we      = (state_q == S_WB) && we_q;
  assign rf_wdata   = wdata_q;
  assign pc         = pc_q;
  assign instret    = instret_q;
  assign halted     = (state_q == S_HALT);

endmodule
`default_nettype wire
